// File: rtl/wave_cfg_pkg.sv
// wave_cfg_pkg: shared field codes, scheduler states and sizing for wave_cfg_sched.
package wave_cfg_pkg;
  localparam int NUM_CH = 8;
  localparam int W = 16;
  typedef enum logic [1:0] {
    FLD_AMP = 2'd0,
    FLD_OFS = 2'd1,
    FLD_PHW = 2'd2,
    FLD_RSV = 2'd3
  } fld_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2
  } state_t;
endpackage

// File: rtl/amp_ramp.sv
// amp_ramp: per-channel amplitude slewing toward its target by at most step per enabled cycle.
module amp_ramp
  import wave_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] target,
  input  logic        [W-1:0] step,
  input  logic                en,
  output logic signed [W-1:0] amp,
  output logic                done
);
  logic signed [W:0] diff;
  logic        [W:0] mag;
  always_comb begin
    diff = {target[W-1], target} - {amp[W-1], amp};
    mag  = diff[W] ? -diff : diff;
    done = mag <= {1'b0, step};
  end
  // done means this step lands exactly on the target, so no overshoot is possible
  always_ff @(posedge clk or posedge reset)
    if (reset) amp <= '0;
    else if (en) amp <= done ? target : (diff[W] ? amp - step : amp + step);
endmodule

// File: rtl/wave_cfg_sched.sv
// wave_cfg_sched: shadow-bank config writes, applied atomically to the active buses on the tick after commit.
// Define WAVE_CFG_RAMP_EN to slew amplitudes by RAMP_STEP per tick instead of jumping.
module wave_cfg_sched
  import wave_cfg_pkg::*;
#(
  parameter logic [15:0] RAMP_STEP = 16'd256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [2:0]   wr_chan,
  input  logic [1:0]   wr_field,
  input  logic [15:0]  wr_data,
  input  logic         commit,
  input  logic         tick,
  output logic         busy,
  output logic         err,
  output logic [127:0] amps,
  output logic [127:0] offsets,
  output logic [127:0] phasewords
);
  state_t state, nxt;
  logic [NUM_CH-1:0][W-1:0] sh_amp, sh_ofs, sh_phw, amp_cur;
  logic acc, apply, all_done;
  if (RAMP_STEP == '0) begin : g_bad_step
    $fatal(1, "RAMP_STEP must be at least 1");
  end
  assign wr_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign acc      = wr_valid & wr_ready;
  assign apply    = (state == ARMED) & tick;
  assign amps     = amp_cur;
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = commit ? ARMED : IDLE;
    else if (tick) nxt = all_done ? IDLE : RAMP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh_amp <= '0;
      sh_ofs <= '0;
      sh_phw <= '0;
      err    <= 1'b0;
    end else if (acc) begin
      if (wr_field == FLD_AMP) sh_amp[wr_chan] <= wr_data;
      if (wr_field == FLD_OFS) sh_ofs[wr_chan] <= wr_data;
      if (wr_field == FLD_PHW) sh_phw[wr_chan] <= wr_data;
      if (wr_field == FLD_RSV) err <= 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      offsets    <= '0;
      phasewords <= '0;
    end else if (apply) begin
      offsets    <= sh_ofs;
      phasewords <= sh_phw;
    end
`ifdef WAVE_CFG_RAMP_EN
  logic [NUM_CH-1:0] done;
  logic step_en;
  // the shadow bank is frozen outside IDLE, so it doubles as the ramp target
  assign step_en  = tick & (state == ARMED | state == RAMP);
  assign all_done = &done;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    amp_ramp u_ramp (
      .clk    (clk),
      .reset  (reset),
      .target (sh_amp[c]),
      .step   (RAMP_STEP),
      .en     (step_en),
      .amp    (amp_cur[c]),
      .done   (done[c])
    );
  end
`else
  assign all_done = 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) amp_cur <= '0;
    else if (apply) amp_cur <= sh_amp;
`endif
endmodule

// File: doc/wave_cfg_sched.md
# wave_cfg_sched

Configuration scheduler for the eight-channel wave summer. Accepts per-channel amplitude, offset and phaseword writes over a valid/ready port into a shadow bank. On a commit request it applies the whole bank to the active outputs atomically on the next sample tick, so the summer never sees a half-updated channel set. Its three 128-bit output buses feed the summer's `amps`, `offsets` and `phasewords` inputs directly.

## Interface
- `RAMP_STEP`, 16'd256: per-tick amplitude step magnitude, used only when ramping is compiled in; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  a write is offered this cycle.
- `wr_ready`  out  1  a write can be accepted this cycle.
- `wr_chan`  in  3  target channel, 0–7.
- `wr_field`  in  2  field select: 0 = amp, 1 = offset, 2 = phaseword, 3 = reserved.
- `wr_data`  in  16  write value; signed for amp, unsigned otherwise.
- `commit`  in  1  single-cycle request to apply the shadow bank.
- `tick`  in  1  sample-boundary strobe, one cycle wide.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  sticky flag, set by an accepted write with `wr_field` = 3.
- `amps`  out  128  active amplitudes, signed; channel n at [16n+15:16n].
- `offsets`  out  128  active offsets, same packing.
- `phasewords`  out  128  active phasewords, same packing.

## Operation
- Reset values: all shadow registers, `amps`, `offsets`, `phasewords` = 0; `err` = 0; state = IDLE; `busy` = 0; `wr_ready` = 1.
- A write transfers on any cycle with `wr_valid` & `wr_ready` high. It updates shadow[`wr_chan`][`wr_field`] at that clock edge.
- A field-3 write changes no register and sets `err`. `err` clears only on reset.
- States:
  - **IDLE:** `wr_ready` = 1. `commit` moves to ARMED.
  - **ARMED:** `wr_ready` = 0, so the shadow bank is frozen. `commit` is ignored. `tick` applies the shadow bank, then goes to IDLE, or to RAMP when ramping is enabled.
  - **RAMP:** `wr_ready` = 0. `commit` is ignored. Each `tick` steps every amp toward its target. Goes to IDLE on the edge where all eight amps equal their targets.
- Same-cycle `wr_valid` and `commit` in IDLE: the write is accepted and included in the commit.
- Same-cycle `commit` and `tick` in IDLE: the FSM arms only. It applies on the next `tick`, never on the same one.
- `tick` in IDLE has no effect.
- Active outputs change only on a tick edge. A channel whose shadow matches its active value is unchanged.
- Reset mid-ARMED or mid-RAMP: everything returns to the reset values immediately, and the pending commit is lost.

## Timing
- `commit` at edge k, then first `tick` sampled at edge m > k: new outputs are visible from cycle m+1.
- `wr_ready` drops in cycle k+1.
- `busy` is registered with the state and asserts in cycle k+1.
- Ramp step per amp, per tick:
  - diff = target − current, computed 17-bit signed.
  - If |diff| ≤ `RAMP_STEP`, current ← target.
  - Otherwise current ± `RAMP_STEP`.
  - No overflow or wrap past the target is possible.
- Ramp duration is ceil(max|diff| / `RAMP_STEP`) ticks, the first step taken on the applying tick.

## Configuration
- `WAVE_CFG_RAMP_EN` defined: on the applying tick, offsets and phasewords jump to their new values and amps take their first step. The RAMP state handles the remaining steps.
- `WAVE_CFG_RAMP_EN` undefined: amps jump with the other fields, RAMP is unreachable, and `RAMP_STEP` is unused.

## Structure
- `wave_cfg_pkg` holds:
  - field codes (`FLD_AMP`, `FLD_OFS`, `FLD_PHW`, `FLD_RSV`);
  - the state enum (IDLE, ARMED, RAMP);
  - `NUM_CH` = 8 and `W` = 16.
- Sub-module `amp_ramp`, one instance per channel: inputs target, `RAMP_STEP` and a step enable; outputs the current amp and a done flag. It is instantiated only under `WAVE_CFG_RAMP_EN`.

## Test plan
- Write ch3 amp = 16'h1000, commit, tick after 5 idle cycles:
  - `amps`[63:48] = 16'h1000 from the cycle after the tick;
  - all other lanes stay 0;
  - `busy` stays high for exactly the ARMED interval.
- Commit and tick in the same cycle:
  - outputs are unchanged after that tick;
  - outputs update only after the second tick.
- While ARMED, hold `wr_valid` with ch0 offset = 16'h00FF:
  - `wr_ready` = 0 and the value is not stored;
  - after apply and return to IDLE, the write is accepted and appears after the next commit and tick.
- Field-3 write: `err` = 1 and stays set after later normal writes; all outputs are unchanged.
- `WAVE_CFG_RAMP_EN`, `RAMP_STEP` = 256, ch7 amp from 0 to −16'd600:
  - successive values −256, −512, −600, one per tick;
  - IDLE after the third tick.
- Assert `reset` in the middle of a ramp:
  - all buses are 0 and `busy` = 0 within the same cycle;
  - `wr_ready` = 1.
